// File: rtl/bu_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bu_buf_pkg
// Brief   : Shared types and width helpers for the butterfly result buffer.
// Revision: 1.0 - initial release
// ============================================================================
package bu_buf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  function automatic int log2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int in_w_f(input int bu_par, input int dw_bram);
    return 4 * dw_bram * bu_par;
  endfunction

  function automatic int epb_f(input int in_w, input int dw_bram);
    return in_w / dw_bram;
  endfunction

  function automatic int ratio_f(input int in_w, input int dw_axi);
    return in_w / dw_axi;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bu_result_buffer_out_fifo.sv
`default_nettype none
// ============================================================================
// Module  : result_out_fifo
// Brief   : 4-entry output FIFO with read credits and a RATIO-slice serializer.
// Revision: 1.0 - initial release
// ============================================================================
module result_out_fifo
  import bu_buf_pkg::*;
#(
  parameter int IN_W  = 256,
  parameter int OUT_W = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [IN_W-1:0]               push_dat,
  input  logic                          push_last,
  output logic [log2_f(FIFO_DEPTH):0]   credit,
  output logic [OUT_W-1:0]              dn_dat,
  output logic                          dn_vld,
  output logic                          dn_last,
  input  logic                          dn_rdy
);

  localparam int RATIO = ratio_f(IN_W, OUT_W);
  localparam int PW    = log2_f(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int SW    = (RATIO > 1) ? log2_f(RATIO) : 1;

  logic [IN_W-1:0]       dat_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_q, last_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         slice_q, slice_d;
  logic [IN_W-1:0]       head;
  logic                  slice_end;
  logic                  pop;

  assign head      = dat_mem[rd_ptr_q];
  assign slice_end = (slice_q == SW'(RATIO - 1));
  assign dn_vld    = (cnt_q != '0);
  assign dn_last   = dn_vld && last_q[rd_ptr_q] && slice_end;
  // Gate the data so an empty FIFO never exposes stale storage
  assign dn_dat    = dn_vld ? head[int'(slice_q) * OUT_W +: OUT_W] : '0;
  assign pop       = dn_vld && dn_rdy && slice_end;
  // Entries already held plus the read landing this cycle are spoken for
  assign credit    = CW'(FIFO_DEPTH) - cnt_q - CW'(push);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    slice_d  = slice_q;
    last_d   = last_q;
    if (push) begin
      last_d[wr_ptr_q] = push_last;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (dn_vld && dn_rdy) begin
      slice_d = slice_end ? '0 : slice_q + SW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) dat_mem[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      slice_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      slice_q  <= slice_d;
      last_q   <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : bu_result_buffer
// Brief   : Ping-pong frame buffer between the butterfly array and DDR writes.
//           Define BU_RESULT_BUF_ERR_EN to build overflow/bad-length checking.
// Revision: 1.0 - initial release
// ============================================================================
module bu_result_buffer
  import bu_buf_pkg::*;
#(
  parameter int BU_PARALLELISM  = 4,
  parameter int DATA_WIDTH_BRAM = 16,
  parameter int DATA_WIDTH_AXI  = 256,
  parameter int DEPTH           = 1024
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic [CNT_W-1:0]                                    length,
  input  logic [in_w_f(BU_PARALLELISM, DATA_WIDTH_BRAM)-1:0]  up_dat,
  input  logic                                                up_vld,
  output logic                                                up_rdy,
  output logic [DATA_WIDTH_AXI-1:0]                           dn_dat,
  output logic                                                dn_vld,
  output logic                                                dn_last,
  input  logic                                                dn_rdy,
  output logic [1:0]                                          err
);

  localparam int IN_W = in_w_f(BU_PARALLELISM, DATA_WIDTH_BRAM);
  localparam int EPB  = epb_f(IN_W, DATA_WIDTH_BRAM);
  localparam int AW   = log2_f(DEPTH);
  localparam int CRW  = log2_f(FIFO_DEPTH) + 1;

  bank_state_e      state_q [2];
  bank_state_e      state_d [2];
  logic [CNT_W-1:0] fb_q [2];
  logic [CNT_W-1:0] fb_d [2];
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             wr_flag_q, wr_flag_d, rd_flag_q, rd_flag_d;
  logic             out_flag_q, out_flag_d;
  logic             rd_active_q, rd_active_d;
  logic             up_rdy_q, up_rdy_d;
  logic             rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;

  logic [IN_W-1:0]  ram [2][DEPTH];
  logic [IN_W-1:0]  ram_rd_dat;
  logic [CRW-1:0]   credit;
  logic [CNT_W-1:0] new_fb, wr_fb;
  logic             wr_acc, wr_last, new_frame;
  logic             rd_sel, rd_issue, rd_last;
  logic             dn_done;
  logic             open_d, open_q;

`ifdef BU_RESULT_BUF_ERR_EN
  logic       len_ok;
  logic [1:0] err_q, err_d;

  assign len_ok = (length != '0) && ((length % CNT_W'(EPB)) == '0) &&
                  (32'(length) <= 32'(DEPTH * EPB));
  // An illegal frame is shrunk to one beat so both banks keep cycling
  assign new_fb = len_ok ? (length / CNT_W'(EPB)) : CNT_W'(1);
  assign err    = err_q;

  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | (up_vld & ~up_rdy_q);
    err_d[1] = err_q[1] | (new_frame & ~len_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end
`else
  assign new_fb = length / CNT_W'(EPB);
  assign err    = '0;
`endif

  assign up_rdy    = up_rdy_q;
  assign wr_acc    = up_vld && up_rdy_q;
  assign new_frame = wr_acc && (state_q[wr_flag_q] == BANK_EMPTY);
  assign wr_fb     = (state_q[wr_flag_q] == BANK_EMPTY) ? new_fb : fb_q[wr_flag_q];
  assign wr_last   = (wr_cnt_q == wr_fb - CNT_W'(1));

  assign rd_sel    = !rd_active_q && (state_q[rd_flag_q] == BANK_FULL);
  assign rd_issue  = (rd_active_q || rd_sel) && (credit != '0);
  assign rd_last   = (rd_cnt_q == fb_q[rd_flag_q] - CNT_W'(1));
  assign dn_done   = dn_vld && dn_rdy && dn_last;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      fb_d[i]    = fb_q[i];
      if (wr_acc && (wr_flag_q == 1'(i))) begin
        if (state_q[i] == BANK_EMPTY) begin
          fb_d[i]    = new_fb;
          state_d[i] = BANK_FILLING;
        end
        if (wr_last) state_d[i] = BANK_FULL;
      end
      if (rd_sel && (rd_flag_q == 1'(i))) state_d[i] = BANK_DRAINING;
      if (dn_done && (out_flag_q == 1'(i))) state_d[i] = BANK_EMPTY;
    end
  end

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_flag_d   = wr_flag_q;
    rd_cnt_d    = rd_cnt_q;
    rd_flag_d   = rd_flag_q;
    rd_active_d = rd_active_q;
    out_flag_d  = out_flag_q;
    rd_vld_d    = rd_issue;
    rd_last_d   = rd_issue && rd_last;
    if (wr_acc) begin
      if (wr_last) begin
        wr_cnt_d  = '0;
        wr_flag_d = ~wr_flag_q;
      end else begin
        wr_cnt_d  = wr_cnt_q + CNT_W'(1);
      end
    end
    if (rd_sel) rd_active_d = 1'b1;
    if (rd_issue) begin
      if (rd_last) begin
        rd_cnt_d    = '0;
        rd_flag_d   = ~rd_flag_q;
        rd_active_d = 1'b0;
      end else begin
        rd_cnt_d    = rd_cnt_q + CNT_W'(1);
      end
    end
    if (dn_done) out_flag_d = ~out_flag_q;
  end

  // Ready needs the bank writable both now and next cycle, so a freed bank
  // only reopens one edge after it empties
  assign open_d   = (state_d[wr_flag_d] == BANK_EMPTY) || (state_d[wr_flag_d] == BANK_FILLING);
  assign open_q   = (state_q[wr_flag_d] == BANK_EMPTY) || (state_q[wr_flag_d] == BANK_FILLING);
  assign up_rdy_d = open_d && open_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0]  <= BANK_EMPTY;
      state_q[1]  <= BANK_EMPTY;
      fb_q[0]     <= '0;
      fb_q[1]     <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_flag_q   <= 1'b0;
      rd_flag_q   <= 1'b0;
      out_flag_q  <= 1'b0;
      rd_active_q <= 1'b0;
      up_rdy_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q[0]  <= state_d[0];
      state_q[1]  <= state_d[1];
      fb_q[0]     <= fb_d[0];
      fb_q[1]     <= fb_d[1];
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_flag_q   <= wr_flag_d;
      rd_flag_q   <= rd_flag_d;
      out_flag_q  <= out_flag_d;
      rd_active_q <= rd_active_d;
      up_rdy_q    <= up_rdy_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)   ram[wr_flag_q][wr_cnt_q[AW-1:0]] <= up_dat;
    if (rd_issue) ram_rd_dat <= ram[rd_flag_q][rd_cnt_q[AW-1:0]];
  end

  result_out_fifo #(
    .IN_W  (IN_W),
    .OUT_W (DATA_WIDTH_AXI)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_vld_q),
    .push_dat  (ram_rd_dat),
    .push_last (rd_last_q),
    .credit    (credit),
    .dn_dat    (dn_dat),
    .dn_vld    (dn_vld),
    .dn_last   (dn_last),
    .dn_rdy    (dn_rdy)
  );

endmodule
`default_nettype wire

// File: tb/tb_bu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bu_result_buffer
// Brief   : Directed self-checking bench for bu_result_buffer (RATIO 1 and 2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_bu_result_buffer;

  logic         clk, rst_n;
  logic [15:0]  length, length2;
  logic [255:0] up_dat, up_dat2;
  logic         up_vld, up_rdy, up_vld2, up_rdy2;
  logic [255:0] dn_dat;
  logic [127:0] dn_dat2;
  logic         dn_vld, dn_last, dn_rdy, dn_vld2, dn_last2, dn_rdy2;
  logic [1:0]   err, err2;

  int n_chk = 0;
  int n_err = 0;
  int acc_cnt = 0;
  logic         stall_q = 1'b0;
  logic [256:0] hold_v;
  logic [256:0] got_q[$];
  logic [256:0] exp_q[$];

  bu_result_buffer u_dut (
    .clk(clk), .rst_n(rst_n), .length(length), .up_dat(up_dat), .up_vld(up_vld),
    .up_rdy(up_rdy), .dn_dat(dn_dat), .dn_vld(dn_vld), .dn_last(dn_last),
    .dn_rdy(dn_rdy), .err(err)
  );

  bu_result_buffer #(.DATA_WIDTH_AXI(128)) u_dut_r2 (
    .clk(clk), .rst_n(rst_n), .length(length2), .up_dat(up_dat2), .up_vld(up_vld2),
    .up_rdy(up_rdy2), .dn_dat(dn_dat2), .dn_vld(dn_vld2), .dn_last(dn_last2),
    .dn_rdy(dn_rdy2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [259:0] got, input logic [259:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] beat_dat(input int f, input int b);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = {8'(f), 8'(b), 8'(k), 8'hA5};
    return r;
  endfunction

  task automatic add_exp(input int f, input int nb);
    for (int b = 0; b < nb; b++) exp_q.push_back({1'(b == nb - 1), beat_dat(f, b)});
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [15:0] len, output int waits);
    waits  = 0;
    up_vld = 1'b0;
    while (!up_rdy && waits < 2000) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!up_rdy) chk("up_rdy_timeout", up_rdy, 1);
    up_vld = 1'b1;
    up_dat = d;
    length = len;
    @(posedge clk); #1;
    up_vld = 1'b0;
  endtask

  task automatic send_frame(input int f, input int nb, input logic [15:0] len,
                            input bit gaps, output int waits);
    int w, g;
    waits = 0;
    for (int b = 0; b < nb; b++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
      send_beat(beat_dat(f, b), len, w);
      waits += w;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Output capture, acceptance counting and stall-stability checks
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (dn_vld && dn_rdy) got_q.push_back({dn_last, dn_dat});
      if (up_vld && up_rdy) acc_cnt++;
      if (stall_q) begin
        chk("hold_vld", dn_vld, 1);
        chk("hold_dat", {dn_last, dn_dat}, hold_v);
      end
      stall_q = dn_vld && !dn_rdy;
      hold_v  = {dn_last, dn_dat};
    end
  end

  initial begin
    int w, tw, n;
    logic [128:0] cap [4];
    logic [255:0] d0, d1;
    rst_n = 1'b0; up_vld = 1'b0; up_dat = '0; length = '0; dn_rdy = 1'b1;
    up_vld2 = 1'b0; up_dat2 = '0; length2 = '0; dn_rdy2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_up_rdy", up_rdy, 0);
    chk("rst_dn_vld", dn_vld, 0);
    chk("rst_dn_last", dn_last, 0);
    chk("rst_dn_dat", dn_dat, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    chk("up_rdy_pre_edge", up_rdy, 0);
    @(posedge clk); #1;
    chk("up_rdy_rise", up_rdy, 1);

    // Single 4-beat frame with latency check
    add_exp(1, 4);
    for (int b = 0; b < 4; b++) send_beat(beat_dat(1, b), 16'd64, w);
    chk("lat_e0_vld", dn_vld, 0);
    @(posedge clk); #1;
    chk("lat_e1_vld", dn_vld, 0);
    @(posedge clk); #1;
    chk("lat_e2_vld", dn_vld, 1);
    chk("lat_e2_dat", dn_dat, beat_dat(1, 0));
    wait_drain("t1_frame");

    // Two back-to-back frames
    add_exp(2, 4);
    add_exp(3, 4);
    send_frame(2, 4, 16'd64, 1'b0, w); tw = w;
    send_frame(3, 4, 16'd64, 1'b0, w); tw += w;
    chk("b2b_waits", tw, 0);
    wait_drain("t2_b2b");

    // Full backpressure with three frames offered
    dn_rdy  = 1'b0;
    acc_cnt = 0;
    add_exp(4, 4); add_exp(5, 4); add_exp(6, 4);
    fork
      begin
        send_frame(4, 4, 16'd64, 1'b0, w);
        send_frame(5, 4, 16'd64, 1'b0, w);
        send_frame(6, 4, 16'd64, 1'b0, w);
      end
      begin
        n = 0;
        while (acc_cnt < 8 && n < 200) begin @(posedge clk); #1; n++; end
        repeat (6) begin @(posedge clk); #1; end
        chk("bp_up_rdy", up_rdy, 0);
        chk("bp_accepted", acc_cnt, 8);
        chk("bp_dn_vld", dn_vld, 1);
        chk("bp_head_dat", dn_dat, beat_dat(4, 0));
        dn_rdy = 1'b1;
      end
    join
    wait_drain("t3_bp");

    // Alternating dn_rdy with random input gaps, including a 1-beat frame
    add_exp(7, 1); add_exp(8, 4); add_exp(9, 3);
    fork
      begin
        send_frame(7, 1, 16'd16, 1'b1, w);
        send_frame(8, 4, 16'd64, 1'b1, w);
        send_frame(9, 3, 16'd48, 1'b1, w);
      end
      begin
        for (int i = 0; i < 120; i++) begin @(posedge clk); #1; dn_rdy = ~dn_rdy; end
      end
    join
    dn_rdy = 1'b1;
    wait_drain("t4_alt");

    // Width down-conversion on the RATIO=2 instance
    chk("r2_up_rdy", up_rdy2, 1);
    d0 = beat_dat(10, 0);
    d1 = beat_dat(10, 1);
    up_vld2 = 1'b1; length2 = 16'd32; up_dat2 = d0;
    @(posedge clk); #1;
    up_dat2 = d1;
    @(posedge clk); #1;
    up_vld2 = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (dn_vld2) begin cap[n] = {dn_last2, dn_dat2}; n++; end
      @(posedge clk); #1;
    end
    chk("r2_count", n, 4);
    chk("r2_s0", cap[0], {1'b0, d0[127:0]});
    chk("r2_s1", cap[1], {1'b0, d0[255:128]});
    chk("r2_s2", cap[2], {1'b0, d1[127:0]});
    chk("r2_s3", cap[3], {1'b1, d1[255:128]});

    // Reset in the middle of a frame
    send_beat(beat_dat(11, 0), 16'd64, w);
    send_beat(beat_dat(11, 1), 16'd64, w);
    rst_n = 1'b0;
    #1;
    chk("mrst_up_rdy", up_rdy, 0);
    chk("mrst_dn_vld", dn_vld, 0);
    chk("mrst_dn_last", dn_last, 0);
    chk("mrst_dn_dat", dn_dat, 0);
    chk("mrst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    add_exp(12, 4);
    send_frame(12, 4, 16'd64, 1'b0, w);
    wait_drain("t6_after_rst");

`ifdef BU_RESULT_BUF_ERR_EN
    rst_n  = 1'b0;
    up_vld = 1'b1;
    length = 16'd64;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    up_vld = 1'b0;
    chk("err_overflow", err, 2'b01);
    repeat (3) begin @(posedge clk); #1; end
    chk("err_sticky", err, 2'b01);
    add_exp(13, 1);
    send_beat(beat_dat(13, 0), 16'd8, w);
    chk("err_bad_len", err, 2'b11);
    wait_drain("t7_bad_len");
`else
    chk("err_tied_low", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
